// File: rtl/square_game_ctrl.sv
// VGA square game controller: UART command decode, tick-paced square movement with screen clamping,
// hole detection and IDLE/PLAY/WIN sequencing; all outputs registered, commands take effect next cycle.
module square_game_ctrl #(
  parameter int SCREEN_W  = 640,
  parameter int SCREEN_H  = 480,
  parameter int SQ_SIZE   = 18,
  parameter int HOLE_X    = 300,
  parameter int HOLE_Y    = 198,
  parameter int HOLE_SIZE = 20,
  parameter int START_X   = 0,
  parameter int START_Y   = 200,
  parameter int TICK_DIV  = 310000,
  parameter int WIN_TICKS = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_data,
  output logic [9:0] sq_x,
  output logic [9:0] sq_y,
  output logic [1:0] state,
  output logic       win_pulse,
  output logic [7:0] score
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_PLAY = 2'd1, S_WIN = 2'd2} state_e;
  typedef enum logic [2:0] {D_STOP, D_UP, D_DOWN, D_RIGHT, D_LEFT} dir_e;

  localparam int TC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int WC_W = (WIN_TICKS > 1) ? $clog2(WIN_TICKS) : 1;

  localparam logic [TC_W-1:0] TICK_LAST = TC_W'(TICK_DIV - 1);
  localparam logic [WC_W-1:0] WIN_LAST  = WC_W'(WIN_TICKS - 1);
  localparam logic [10:0]     X_MAX     = 11'(SCREEN_W - SQ_SIZE);
  localparam logic [10:0]     Y_MAX     = 11'(SCREEN_H - SQ_SIZE);
  localparam logic [9:0]      X_START   = 10'(START_X);
  localparam logic [9:0]      Y_START   = 10'(START_Y);
  localparam logic [9:0]      HOLE_X_LO = 10'(HOLE_X);
  localparam logic [9:0]      HOLE_X_HI = 10'(HOLE_X + HOLE_SIZE - SQ_SIZE);
  localparam logic [9:0]      HOLE_Y_LO = 10'(HOLE_Y);
  localparam logic [9:0]      HOLE_Y_HI = 10'(HOLE_Y + HOLE_SIZE - SQ_SIZE);

  state_e           state_q, state_d;
  dir_e             dir_q, dir_d;
  logic [9:0]       x_q, x_d, y_q, y_d;
  logic [TC_W-1:0]  tick_cnt_q, tick_cnt_d;
  logic [WC_W-1:0]  win_cnt_q, win_cnt_d;
  logic             win_pulse_q, win_pulse_d;
  logic [7:0]       score_q, score_d;

  logic             tick;
  logic             cmd_is_dir, cmd_stop, cmd_restart;
  dir_e             cmd_dir;
  logic [10:0]      x_step, y_step;
  logic [9:0]       x_clamp, y_clamp;
  logic             win_hit;

  always_comb begin
    cmd_is_dir = 1'b0;
    cmd_dir    = D_STOP;
    if (cmd_valid) begin
      case (cmd_data)
        8'd65: begin cmd_is_dir = 1'b1; cmd_dir = D_UP;    end
        8'd66: begin cmd_is_dir = 1'b1; cmd_dir = D_DOWN;  end
        8'd67: begin cmd_is_dir = 1'b1; cmd_dir = D_RIGHT; end
        8'd68: begin cmd_is_dir = 1'b1; cmd_dir = D_LEFT;  end
        default: ;
      endcase
    end
  end

  assign cmd_stop    = cmd_valid && (cmd_data == 8'd32);
  assign cmd_restart = cmd_valid && (cmd_data == 8'd82);

  // Free-running movement divider; never cleared except by rst.
  assign tick       = (tick_cnt_q == TICK_LAST);
  assign tick_cnt_d = tick ? '0 : tick_cnt_q + TC_W'(1);

  // 11-bit step so +1 cannot wrap; decrement at 0 is suppressed rather than underflowing.
  always_comb begin
    x_step = {1'b0, x_q};
    y_step = {1'b0, y_q};
    case (dir_q)
      D_RIGHT: x_step = {1'b0, x_q} + 11'd1;
      D_LEFT:  x_step = (x_q == 10'd0) ? 11'd0 : {1'b0, x_q} - 11'd1;
      D_DOWN:  y_step = {1'b0, y_q} + 11'd1;
      D_UP:    y_step = (y_q == 10'd0) ? 11'd0 : {1'b0, y_q} - 11'd1;
      default: ;
    endcase
    x_clamp = (x_step > X_MAX) ? X_MAX[9:0] : x_step[9:0];
    y_clamp = (y_step > Y_MAX) ? Y_MAX[9:0] : y_step[9:0];
  end

  assign win_hit = (state_q == S_PLAY) &&
                   (x_q >= HOLE_X_LO) && (x_q <= HOLE_X_HI) &&
                   (y_q >= HOLE_Y_LO) && (y_q <= HOLE_Y_HI);

  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    x_d         = x_q;
    y_d         = y_q;
    win_cnt_d   = win_cnt_q;
    win_pulse_d = 1'b0;
    score_d     = score_q;
    // Restart outranks a coincident tick or win.
    if (cmd_restart) begin
      state_d   = S_IDLE;
      dir_d     = D_STOP;
      x_d       = X_START;
      y_d       = Y_START;
      win_cnt_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          x_d = X_START;
          y_d = Y_START;
          if (cmd_is_dir) begin
            dir_d   = cmd_dir;
            state_d = S_PLAY;
          end
        end
        S_PLAY: begin
          if (win_hit) begin
            state_d     = S_WIN;
            dir_d       = D_STOP;
            win_cnt_d   = '0;
            win_pulse_d = 1'b1;
            score_d     = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
          end else begin
            // Step uses the direction already registered; a new command lands for the next tick.
            if (tick) begin
              x_d = x_clamp;
              y_d = y_clamp;
            end
            if (cmd_is_dir) dir_d = cmd_dir;
            else if (cmd_stop) dir_d = D_STOP;
          end
        end
        S_WIN: begin
          if (tick) begin
            if (win_cnt_q == WIN_LAST) begin
              state_d   = S_IDLE;
              x_d       = X_START;
              y_d       = Y_START;
              win_cnt_d = '0;
            end else begin
              win_cnt_d = win_cnt_q + WC_W'(1);
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      dir_q       <= D_STOP;
      x_q         <= X_START;
      y_q         <= Y_START;
      tick_cnt_q  <= '0;
      win_cnt_q   <= '0;
      win_pulse_q <= 1'b0;
      score_q     <= 8'd0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      x_q         <= x_d;
      y_q         <= y_d;
      tick_cnt_q  <= tick_cnt_d;
      win_cnt_q   <= win_cnt_d;
      win_pulse_q <= win_pulse_d;
      score_q     <= score_d;
    end
  end

  assign sq_x      = x_q;
  assign sq_y      = y_q;
  assign state     = state_q;
  assign win_pulse = win_pulse_q;
  assign score     = score_q;

endmodule

// File: tb/tb_square_game_ctrl.sv
// Directed bench for square_game_ctrl; a second instance with a hole next to START drives score saturation.
module tb_square_game_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_data = 8'd0;
  logic [9:0] sq_x, sq_y, fx, fy;
  logic [1:0] state, fstate;
  logic       win_pulse, fpulse;
  logic [7:0] score, fscore;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  // Posedges since reset release; the DUT tick counter equals cyc % 4, steps land on posedges cyc%4==0.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  square_game_ctrl #(.TICK_DIV(4), .WIN_TICKS(3)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
    .sq_x(sq_x), .sq_y(sq_y), .state(state), .win_pulse(win_pulse), .score(score)
  );

  square_game_ctrl #(.TICK_DIV(4), .WIN_TICKS(3), .HOLE_X(2)) dut_fast (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
    .sq_x(fx), .sq_y(fy), .state(fstate), .win_pulse(fpulse), .score(fscore)
  );

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_data  = b;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_data  = 8'd0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (sq_x !== 10'd0) begin n_bad++; $display("FAIL reset_sq_x: got %0d want 0", sq_x); end
    n_cmp++; if (sq_y !== 10'd200) begin n_bad++; $display("FAIL reset_sq_y: got %0d want 200", sq_y); end
    n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", state); end
    n_cmp++; if (win_pulse !== 1'b0) begin n_bad++; $display("FAIL reset_win_pulse: got %0b want 0", win_pulse); end
    n_cmp++; if (score !== 8'd0) begin n_bad++; $display("FAIL reset_score: got %0d want 0", score); end
    rst = 1'b0;
  endtask

  int win_cyc;

  task automatic test_play_to_win;
    logic [9:0] x0;
    int n;
    send(8'd67);
    n_cmp++; if (state !== 2'd1) begin n_bad++; $display("FAIL play_enter_state: got %0d want 1", state); end
    n_cmp++; if (sq_x !== 10'd0) begin n_bad++; $display("FAIL play_enter_x: got %0d want 0", sq_x); end
    while (cyc % 4 != 0) @(negedge clk);
    x0 = sq_x;
    repeat (3) @(negedge clk);
    n_cmp++; if (sq_x !== x0) begin n_bad++; $display("FAIL step_hold_between_ticks: got %0d want %0d", sq_x, x0); end
    @(negedge clk);
    n_cmp++; if (sq_x !== x0 + 10'd1) begin n_bad++; $display("FAIL step_on_tick: got %0d want %0d", sq_x, x0 + 10'd1); end
    n = 0;
    while (win_pulse !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
    n_cmp++; if (n >= 2000) begin n_bad++; $display("FAIL win_pulse_timeout: got none want pulse within 2000 cycles"); end
    win_cyc = cyc;
    n_cmp++; if (sq_x !== 10'd300) begin n_bad++; $display("FAIL win_sq_x: got %0d want 300", sq_x); end
    n_cmp++; if (sq_y !== 10'd200) begin n_bad++; $display("FAIL win_sq_y: got %0d want 200", sq_y); end
    n_cmp++; if (state !== 2'd2) begin n_bad++; $display("FAIL win_state: got %0d want 2", state); end
    n_cmp++; if (score !== 8'd1) begin n_bad++; $display("FAIL win_score: got %0d want 1", score); end
    @(negedge clk);
    n_cmp++; if (win_pulse !== 1'b0) begin n_bad++; $display("FAIL win_pulse_width: got %0b want 0", win_pulse); end
  endtask

  task automatic test_win_timeout;
    int third;
    third = (win_cyc / 4 + 1) * 4 + 8;
    send(8'd67);
    n_cmp++; if (state !== 2'd2) begin n_bad++; $display("FAIL win_ignores_cmd_state: got %0d want 2", state); end
    n_cmp++; if (sq_x !== 10'd300) begin n_bad++; $display("FAIL win_frozen_x: got %0d want 300", sq_x); end
    while (cyc < third - 1) @(negedge clk);
    n_cmp++; if (state !== 2'd2) begin n_bad++; $display("FAIL win_before_third_tick: got %0d want 2", state); end
    @(negedge clk);
    n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL win_to_idle_state: got %0d want 0", state); end
    n_cmp++; if (sq_x !== 10'd0 || sq_y !== 10'd200) begin n_bad++; $display("FAIL win_to_idle_pos: got %0d,%0d want 0,200", sq_x, sq_y); end
  endtask

  task automatic test_clamp;
    send(8'd68);
    n_cmp++; if (state !== 2'd1) begin n_bad++; $display("FAIL clamp_left_state: got %0d want 1", state); end
    repeat (40) @(negedge clk);
    n_cmp++; if (sq_x !== 10'd0) begin n_bad++; $display("FAIL clamp_left_x: got %0d want 0", sq_x); end
    send(8'd66);
    repeat (1220) @(negedge clk);
    n_cmp++; if (sq_y !== 10'd462) begin n_bad++; $display("FAIL clamp_bottom_y: got %0d want 462", sq_y); end
    n_cmp++; if (sq_x !== 10'd0) begin n_bad++; $display("FAIL clamp_bottom_x: got %0d want 0", sq_x); end
    repeat (20) @(negedge clk);
    n_cmp++; if (sq_y !== 10'd462) begin n_bad++; $display("FAIL clamp_bottom_hold: got %0d want 462", sq_y); end
  endtask

  task automatic test_cmd_on_tick;
    send(8'd32);
    send(8'd82);
    n_cmp++; if (state !== 2'd0 || sq_y !== 10'd200) begin n_bad++; $display("FAIL restart_from_play: got state %0d y %0d want 0 200", state, sq_y); end
    send(8'd68);
    send(8'd32);
    n_cmp++; if (state !== 2'd1 || sq_x !== 10'd0) begin n_bad++; $display("FAIL stop_in_play: got state %0d x %0d want 1 0", state, sq_x); end
    while (cyc % 4 != 3) @(negedge clk);
    cmd_valid = 1'b1;
    cmd_data  = 8'd67;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_data  = 8'd0;
    n_cmp++; if (sq_x !== 10'd0) begin n_bad++; $display("FAIL tick_uses_old_dir: got %0d want 0", sq_x); end
    repeat (3) @(negedge clk);
    n_cmp++; if (sq_x !== 10'd0) begin n_bad++; $display("FAIL tick_new_dir_wait: got %0d want 0", sq_x); end
    @(negedge clk);
    n_cmp++; if (sq_x !== 10'd1) begin n_bad++; $display("FAIL tick_new_dir_step: got %0d want 1", sq_x); end
  endtask

  task automatic test_restart_and_junk;
    logic [9:0] x1;
    int n;
    n = 0;
    while (sq_x !== 10'd150 && n < 1000) begin @(negedge clk); n++; end
    n_cmp++; if (n >= 1000) begin n_bad++; $display("FAIL reach_150_timeout: got %0d want 150", sq_x); end
    cmd_valid = 1'b1;
    cmd_data  = 8'd82;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_data  = 8'd0;
    n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL restart_state: got %0d want 0", state); end
    n_cmp++; if (sq_x !== 10'd0 || sq_y !== 10'd200) begin n_bad++; $display("FAIL restart_pos: got %0d,%0d want 0,200", sq_x, sq_y); end
    n_cmp++; if (score !== 8'd1) begin n_bad++; $display("FAIL restart_keeps_score: got %0d want 1", score); end
    repeat (8) @(negedge clk);
    send(8'h00);
    send(8'h7F);
    n_cmp++; if (state !== 2'd0 || sq_x !== 10'd0) begin n_bad++; $display("FAIL junk_in_idle: got state %0d x %0d want 0 0", state, sq_x); end
    send(8'd67);
    repeat (12) @(negedge clk);
    x1 = sq_x;
    send(8'h7F);
    send(8'h00);
    repeat (12) @(negedge clk);
    n_cmp++; if (state !== 2'd1 || sq_x !== x1 + 10'd4) begin n_bad++; $display("FAIL junk_in_play: got state %0d x %0d want 1 %0d", state, sq_x, x1 + 10'd4); end
  endtask

  task automatic test_async_reset;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (sq_x !== 10'd0 || sq_y !== 10'd200) begin n_bad++; $display("FAIL async_rst_pos: got %0d,%0d want 0,200", sq_x, sq_y); end
    n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL async_rst_state: got %0d want 0", state); end
    n_cmp++; if (score !== 8'd0) begin n_bad++; $display("FAIL async_rst_score: got %0d want 0", score); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_score_saturate;
    int n;
    for (int i = 0; i < 256; i++) begin
      send(8'd67);
      n = 0;
      while (fpulse !== 1'b1 && n < 40) begin @(negedge clk); n++; end
      if (n >= 40) begin
        n_cmp++; n_bad++;
        $display("FAIL sat_win_timeout: got no win at iteration %0d want win", i);
        break;
      end
      if (i == 0) begin
        n_cmp++; if (fscore !== 8'd1) begin n_bad++; $display("FAIL sat_first_win: got %0d want 1", fscore); end
      end
      if (i == 254) begin
        n_cmp++; if (fscore !== 8'd255) begin n_bad++; $display("FAIL sat_255th_win: got %0d want 255", fscore); end
      end
      n = 0;
      while (fstate !== 2'd0 && n < 40) begin @(negedge clk); n++; end
      if (n >= 40) begin
        n_cmp++; n_bad++;
        $display("FAIL sat_idle_timeout: got state %0d at iteration %0d want 0", fstate, i);
        break;
      end
    end
    n_cmp++; if (fscore !== 8'd255) begin n_bad++; $display("FAIL sat_256th_win: got %0d want 255", fscore); end
  endtask

  initial begin
    test_reset();
    test_play_to_win();
    test_win_timeout();
    test_clamp();
    test_cmd_on_tick();
    test_restart_and_junk();
    test_async_reset();
    test_score_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
